// File: rtl/scim_bank_sequencer_if.sv
// Command and bank-controller strobe bundle for scim_bank_sequencer.
// slave is the sequencer side; master is the command/bank-controller side.
interface scim_bank_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_len;
    logic             cmd_two_phase;
    logic             abort;
    logic             READ_DONE;
    logic             COMP_EN;
    logic             READ_EN;
    logic             WRITE_EN;
    logic             comp_positive_phase;
    logic             SA_Latch;
    logic             BnkCtr_En;
    logic             BnkCtr_Latch;
    logic             BnkCtr_Clr;
    logic             BnkCtr_Buffer_Clr;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_two_phase, abort, READ_DONE,
        input  cmd_ready, COMP_EN, READ_EN, WRITE_EN, comp_positive_phase,
               SA_Latch, BnkCtr_En, BnkCtr_Latch, BnkCtr_Clr, BnkCtr_Buffer_Clr,
               busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_two_phase, abort, READ_DONE,
        output cmd_ready, COMP_EN, READ_EN, WRITE_EN, comp_positive_phase,
               SA_Latch, BnkCtr_En, BnkCtr_Latch, BnkCtr_Clr, BnkCtr_Buffer_Clr,
               busy, done, err
    );
endinterface

// File: rtl/scim_bank_sequencer.sv
// Command-driven sequencer producing per-bank SCIM compute/read/write strobes.
// Strobes are registered decodes of the next state so they line up with the state itself.
module scim_bank_sequencer #(
    parameter int CNT_W      = 8,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    scim_bank_sequencer_if.slave  bus
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CLR     = 4'd1;
    localparam logic [3:0] S_COMP    = 4'd2;
    localparam logic [3:0] S_DRAIN   = 4'd3;
    localparam logic [3:0] S_LATCH   = 4'd4;
    localparam logic [3:0] S_RD      = 4'd5;
    localparam logic [3:0] S_RD_WAIT = 4'd6;
    localparam logic [3:0] S_WR      = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic [3:0]       r_state;
    logic             r_phase2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_two;
    logic             r_comp_en, r_read_en, r_write_en, r_sa_en;
    logic             r_clr, r_buf_clr, r_latch, r_pos, r_done, r_err;

    logic [3:0]       w_state_next;
    logic             w_phase2_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_err_next;
    logic             w_accept;
    logic             w_abort;
    logic             w_phase2_span;

    // abort in IDLE both does nothing and blocks acceptance
    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid && !bus.abort;
    assign w_abort  = (r_state != S_IDLE) && bus.abort;

    always_comb begin
        w_state_next  = r_state;
        w_phase2_next = r_phase2;
        w_cnt_next    = r_cnt;
        w_err_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_phase2_next = 1'b0;
                    case (bus.cmd_op)
                        2'b00:   w_state_next = (bus.cmd_len == '0) ? S_DONE : S_CLR;
                        2'b01:   w_state_next = S_RD;
                        2'b10:   w_state_next = S_WR;
                        default: begin
                            w_state_next = S_DONE;
                            w_err_next   = 1'b1;
                        end
                    endcase
                end
            end
            S_CLR: begin
                w_state_next = S_COMP;
                w_cnt_next   = r_len;
            end
            S_COMP: begin
                if (r_cnt == ONE) w_state_next = S_DRAIN;
                else              w_cnt_next   = r_cnt - ONE;
            end
            S_DRAIN: w_state_next = S_LATCH;
            S_LATCH: begin
                if (r_two && !r_phase2) begin
                    w_state_next  = S_CLR;
                    w_phase2_next = 1'b1;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_RD: begin
                w_state_next = S_RD_WAIT;
                w_cnt_next   = TIMEOUT_LD;
            end
            S_RD_WAIT: begin
                if (bus.READ_DONE) begin
                    w_state_next = S_DONE;
                end else if (r_cnt == ONE) begin
                    w_state_next = S_DONE;
                    w_err_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - ONE;
                end
            end
            S_WR:    w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_err_next   = 1'b0;
        end
    end

    assign w_phase2_span = w_phase2_next &&
                           ((w_state_next == S_CLR)   || (w_state_next == S_COMP) ||
                            (w_state_next == S_DRAIN) || (w_state_next == S_LATCH));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_phase2   <= 1'b0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_two      <= 1'b0;
            r_comp_en  <= 1'b0;
            r_read_en  <= 1'b0;
            r_write_en <= 1'b0;
            r_sa_en    <= 1'b0;
            r_clr      <= 1'b0;
            r_buf_clr  <= 1'b0;
            r_latch    <= 1'b0;
            r_pos      <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_phase2 <= w_phase2_next;
            r_cnt    <= w_cnt_next;
            if (w_accept) begin
                r_len <= bus.cmd_len;
                r_two <= bus.cmd_two_phase;
            end
            r_comp_en  <= (w_state_next == S_COMP);
            r_read_en  <= (w_state_next == S_RD);
            r_write_en <= (w_state_next == S_WR);
            // one-cycle delayed copy of COMP_EN, killed immediately on abort
            r_sa_en    <= w_abort ? 1'b0 : r_comp_en;
            r_clr      <= (w_state_next == S_CLR);
            r_buf_clr  <= (w_state_next == S_CLR) && !w_phase2_next;
            r_latch    <= (w_state_next == S_LATCH);
            r_pos      <= !w_phase2_span;
            r_done     <= (w_state_next == S_DONE);
            r_err      <= (w_state_next == S_DONE) && w_err_next;
        end
    end

    assign bus.cmd_ready           = (r_state == S_IDLE);
    assign bus.busy                = (r_state != S_IDLE);
    assign bus.COMP_EN             = r_comp_en;
    assign bus.READ_EN             = r_read_en;
    assign bus.WRITE_EN            = r_write_en;
    assign bus.comp_positive_phase = r_pos;
    assign bus.SA_Latch            = r_sa_en;
    assign bus.BnkCtr_En           = r_sa_en;
    assign bus.BnkCtr_Latch        = r_latch;
    assign bus.BnkCtr_Clr          = r_clr;
    assign bus.BnkCtr_Buffer_Clr   = r_buf_clr;
    assign bus.done                = r_done;
    assign bus.err                 = r_err;
endmodule

// File: tb/tb_scim_bank_sequencer.sv
// Self-checking bench for scim_bank_sequencer: per-cycle output vectors compared
// against a timing model built from offsets relative to the acceptance cycle.
module tb_scim_bank_sequencer;
    localparam int CNT_W = 8;
    localparam int T     = 15;
    localparam int NEVER = 99;
    // {ready, busy, done, err, pos, comp, rd, wr, sa, ben, clr, bufclr, latch}
    localparam logic [12:0] IDLE_V = 13'h1100;

    logic CLK = 1'b0;
    logic RESET_N;
    int   checks = 0;
    int   errors = 0;

    scim_bank_sequencer_if #(.CNT_W(CNT_W)) bus ();

    scim_bank_sequencer #(.CNT_W(CNT_W), .RD_TIMEOUT(T)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    logic [12:0] obs;
    assign obs = {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.comp_positive_phase,
                  bus.COMP_EN, bus.READ_EN, bus.WRITE_EN, bus.SA_Latch, bus.BnkCtr_En,
                  bus.BnkCtr_Clr, bus.BnkCtr_Buffer_Clr, bus.BnkCtr_Latch};

    function automatic bit in_rng(int k, int lo, int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    function automatic bit rd_hit(int rdk);
        return in_rng(rdk, 2, 1 + T);
    endfunction

    function automatic int done_at(int op, int len, int two, int rdk);
        case (op)
            0:       return (len == 0) ? 1 : ((two != 0) ? 7 + 2 * len : 4 + len);
            1:       return rd_hit(rdk) ? rdk + 1 : 2 + T;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [12:0] expect_at(int k, int op, int len, int two, int rdk, int ab);
        logic [12:0] v;
        int d;
        bit tp;
        d  = done_at(op, len, two, rdk);
        tp = (two != 0);
        if (k == 0 || (ab > 0 && k > ab) || k > d) return IDLE_V;
        v     = '0;
        v[11] = 1'b1;
        v[8]  = 1'b1;
        if (k == d) begin
            v[10] = 1'b1;
            v[9]  = (op == 3) || (op == 1 && !rd_hit(rdk));
        end
        if (op == 0 && len > 0) begin
            v[7] = in_rng(k, 2, 1 + len) || (tp && in_rng(k, 5 + len, 4 + 2 * len));
            v[4] = in_rng(k, 3, 2 + len) || (tp && in_rng(k, 6 + len, 5 + 2 * len));
            v[3] = v[4];
            v[2] = (k == 1) || (tp && k == 4 + len);
            v[1] = (k == 1);
            v[0] = (k == 3 + len) || (tp && k == 6 + 2 * len);
            v[8] = !(tp && in_rng(k, 4 + len, 6 + 2 * len));
        end else if (op == 1) begin
            v[6] = (k == 1);
        end else if (op == 2) begin
            v[5] = (k == 1);
        end
        return v;
    endfunction

    task automatic run_cmd(string name, int op, int len, int two, int rdk, int ab);
        int d;
        int last;
        logic [12:0] e;
        d    = done_at(op, len, two, rdk);
        last = (ab > 0 && ab < d) ? ab : d;
        $display("cmd %s op=%0d len=%0d two=%0d rd_done_at=%0d abort_at=%0d done_at=%0d",
                 name, op, len, two, rdk, ab, d);
        for (int k = 0; k <= last; k++) begin
            @(negedge CLK);
            e = expect_at(k, op, len, two, rdk, ab);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s k=%0d got=%b exp=%b", name, k, obs, e);
            end
            if (k == 0) begin
                bus.cmd_valid     = 1'b1;
                bus.cmd_op        = 2'(op);
                bus.cmd_len       = CNT_W'(len);
                bus.cmd_two_phase = (two != 0);
            end else begin
                bus.cmd_valid     = 1'($urandom_range(0, 1));
                bus.cmd_op        = 2'($urandom_range(0, 3));
                bus.cmd_len       = CNT_W'($urandom_range(0, 255));
                bus.cmd_two_phase = 1'($urandom_range(0, 1));
            end
            bus.READ_DONE = (k == rdk);
            bus.abort     = (ab > 0 && k == ab);
        end
    endtask

    task automatic drive_idle();
        bus.cmd_valid     = 1'b0;
        bus.cmd_op        = 2'b00;
        bus.cmd_len       = '0;
        bus.cmd_two_phase = 1'b0;
        bus.abort         = 1'b0;
        bus.READ_DONE     = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (obs !== IDLE_V) begin
                errors++;
                $display("FAIL reset cycle=%0d got=%b exp=%b", i, obs, IDLE_V);
            end
        end
        RESET_N = 1'b1;
    endtask

    task automatic test_compute_single();
        run_cmd("compute_L3", 0, 3, 0, NEVER, 0);
    endtask

    task automatic test_compute_two();
        run_cmd("compute_L2_two", 0, 2, 1, NEVER, 0);
    endtask

    task automatic test_read();
        run_cmd("read_done3", 1, 0, 0, 3, 0);
        run_cmd("read_early_done", 1, 0, 0, 1, 0);
        run_cmd("read_timeout", 1, 0, 0, NEVER, 0);
    endtask

    task automatic test_write();
        run_cmd("write", 2, 0, 0, NEVER, 0);
    endtask

    task automatic test_abort();
        run_cmd("compute_L5_abort4", 0, 5, 0, NEVER, 4);
        run_cmd("write_after_abort", 2, 0, 0, NEVER, 0);
        run_cmd("compute_L2_two_abort8", 0, 2, 1, NEVER, 8);
    endtask

    task automatic test_len0_reserved();
        run_cmd("compute_L0", 0, 0, 1, NEVER, 0);
        run_cmd("reserved", 3, 7, 0, NEVER, 0);
    endtask

    task automatic test_idle_noise();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (obs !== IDLE_V) begin
                errors++;
                $display("FAIL idle_noise cycle=%0d got=%b exp=%b", i, obs, IDLE_V);
            end
            bus.cmd_valid     = 1'b1;
            bus.cmd_op        = 2'($urandom_range(0, 3));
            bus.cmd_len       = CNT_W'($urandom_range(1, 9));
            bus.cmd_two_phase = 1'($urandom_range(0, 1));
            bus.abort         = 1'b1;
            bus.READ_DONE     = 1'($urandom_range(0, 1));
        end
        @(negedge CLK);
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL idle_noise_end got=%b exp=%b", obs, IDLE_V);
        end
        drive_idle();
        bus.READ_DONE = 1'b1;
    endtask

    task automatic test_mid_reset();
        @(negedge CLK);
        drive_idle();
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = CNT_W'(5);
        @(negedge CLK);
        bus.cmd_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (obs[11] !== 1'b1 || obs[7] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre got=%b exp busy=1 comp=1", obs);
        end
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL mid_reset_async got=%b exp=%b", obs, IDLE_V);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL mid_reset_release got=%b exp=%b", obs, IDLE_V);
        end
    endtask

    task automatic test_back_to_back();
        int op, len, two, rdk, ab, d;
        for (int n = 0; n < 40; n++) begin
            op  = $urandom_range(0, 3);
            len = $urandom_range(0, 6);
            two = $urandom_range(0, 1);
            rdk = $urandom_range(1, 18);
            d   = done_at(op, len, two, rdk);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, d) : 0;
            run_cmd("random", op, len, two, rdk, ab);
        end
        @(negedge CLK);
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL final_idle got=%b exp=%b", obs, IDLE_V);
        end
    endtask

    initial begin
        test_reset();
        test_compute_single();
        test_compute_two();
        test_read();
        test_write();
        test_abort();
        test_len0_reserved();
        test_idle_noise();
        test_compute_single();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
